// File: rtl/tetris_pkg.sv
// Shared definitions for the Tetris move scheduler: op codes, FSM states,
// button indices and the score-to-level helper.
package tetris_pkg;

    typedef enum logic [2:0] {
        OP_NEW   = 3'd0,
        OP_LEFT  = 3'd1,
        OP_RIGHT = 3'd2,
        OP_ROT   = 3'd3,
        OP_DROP  = 3'd4,
        OP_LOCK  = 3'd5,
        OP_CLEAR = 3'd6,
        OP_SPAWN = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PLAY  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_LOCK  = 3'd3,
        ST_CLEAR = 3'd4,
        ST_SPAWN = 3'd5,
        ST_OVER  = 3'd6
    } state_e;

    localparam int LEVEL_THR = 7;

    localparam int B_LEFT  = 0;
    localparam int B_RIGHT = 1;
    localparam int B_DOWN  = 2;
    localparam int B_ROT   = 3;
    localparam int B_START = 4;

    // Count of thresholds k*step (k = 1..7) met by score; unrolls to a compare chain.
    function automatic logic [2:0] level_of(input logic [31:0] score, input int step);
        logic [2:0]  lvl;
        logic [31:0] thr;
        lvl = 3'd0;
        for (int k = 1; k <= LEVEL_THR; k++) begin
            thr = k * step;
            if (score >= thr) begin
                lvl = lvl + 3'd1;
            end else begin
                lvl = lvl;
            end
        end
        return lvl;
    endfunction

endpackage

// File: rtl/tetris_grav_timer.sv
// Gravity timer: counts while run is high and pulses tick once per interval.
// The interval is re-latched from level only when the count restarts.
module tetris_grav_timer
    import tetris_pkg::*;
#(
    parameter int TICK_BASE = 50_000_000,
    parameter int TICK_MIN  = 3_125_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       clr,
    input  logic [2:0] level,
    output logic       tick
);

    localparam logic [31:0] BASE_C = TICK_BASE;
    localparam logic [31:0] MIN_C  = TICK_MIN;

    function automatic logic [31:0] interval_of(input logic [2:0] lvl);
        logic [31:0] sh;
        sh = BASE_C >> lvl;
        if (sh < MIN_C) begin
            return MIN_C;
        end else begin
            return sh;
        end
    endfunction

    logic [31:0] cnt_r;
    logic [31:0] intv_r;
    logic        tick_r;

    assign tick = tick_r;

    // Counter, latched interval and registered tick pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= 32'd0;
            intv_r <= interval_of(3'd0);
            tick_r <= 1'b0;
        end else if (clr) begin
            cnt_r  <= 32'd0;
            intv_r <= interval_of(level);
            tick_r <= 1'b0;
        end else if (run) begin
            if (cnt_r >= intv_r - 32'd1) begin
                cnt_r  <= 32'd0;
                intv_r <= interval_of(level);
                tick_r <= 1'b1;
            end else begin
                cnt_r  <= cnt_r + 32'd1;
                tick_r <= 1'b0;
            end
        end else begin
            tick_r <= 1'b0;
        end
    end

endmodule

// File: rtl/tetris_sched.sv
// Move scheduler: arbitrates button and gravity requests onto the engine op
// port and sequences the lock/clear/spawn chain and the new-game flow.
module tetris_sched
    import tetris_pkg::*;
#(
    parameter int TICK_BASE  = 50_000_000,
    parameter int TICK_MIN   = 3_125_000,
    parameter int LEVEL_STEP = 100,
    parameter int SCORE_W    = 13
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_down,
    input  logic               btn_rot,
    input  logic               btn_start,
    input  logic [SCORE_W-1:0] score,
    output logic               op_valid,
    output logic [2:0]         op_code,
    input  logic               op_done,
    input  logic               op_ok,
    output logic [2:0]         level,
    output logic               playing,
    output logic               game_over
);

    state_e     state_r, state_nxt_s;
    logic       op_valid_r, op_valid_nxt_s;
    op_e        op_code_r, op_code_nxt_s;
    logic [2:0] level_r;
    logic       playing_r, game_over_r;

    logic [4:0] btn_s, btn_prev_r, btn_edge_s;
    logic [3:0] pend_r, pend_nxt_s, grant_s;
    logic       grav_pend_r, grav_nxt_s, grant_grav_s;
    logic       flush_s, arm_s, run_s, tick_s;

    assign btn_s      = {btn_start, btn_rot, btn_down, btn_right, btn_left};
    assign btn_edge_s = btn_s & ~btn_prev_r;
    assign arm_s      = (state_r != ST_IDLE) && (state_r != ST_OVER);
    assign run_s      = (state_r == ST_PLAY) || (state_r == ST_ISSUE);

    assign op_valid  = op_valid_r;
    assign op_code   = op_code_r;
    assign level     = level_r;
    assign playing   = playing_r;
    assign game_over = game_over_r;

    tetris_grav_timer #(
        .TICK_BASE (TICK_BASE),
        .TICK_MIN  (TICK_MIN)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run_s),
        .clr   (flush_s),
        .level (level_r),
        .tick  (tick_s)
    );

    // Next state, next op and grant selection.
    always_comb begin
        state_nxt_s    = state_r;
        op_valid_nxt_s = op_valid_r;
        op_code_nxt_s  = op_code_r;
        grant_s        = 4'd0;
        grant_grav_s   = 1'b0;
        flush_s        = 1'b0;
        case (state_r)
            ST_IDLE, ST_OVER: begin
                if (op_valid_r) begin
                    if (op_done) begin
                        op_valid_nxt_s = 1'b0;
                        state_nxt_s    = ST_SPAWN;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end else if (btn_edge_s[B_START]) begin
                    op_valid_nxt_s = 1'b1;
                    op_code_nxt_s  = OP_NEW;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_PLAY: begin
                if (grav_pend_r) begin
                    grant_grav_s  = 1'b1;
                    op_code_nxt_s = OP_DROP;
                end else if (pend_r[B_DOWN]) begin
                    grant_s[B_DOWN] = 1'b1;
                    op_code_nxt_s   = OP_DROP;
                end else if (pend_r[B_ROT]) begin
                    grant_s[B_ROT] = 1'b1;
                    op_code_nxt_s  = OP_ROT;
                end else if (pend_r[B_LEFT]) begin
                    grant_s[B_LEFT] = 1'b1;
                    op_code_nxt_s   = OP_LEFT;
                end else if (pend_r[B_RIGHT]) begin
                    grant_s[B_RIGHT] = 1'b1;
                    op_code_nxt_s    = OP_RIGHT;
                end else begin
                    op_code_nxt_s = op_code_r;
                end
                if (grav_pend_r || (|pend_r)) begin
                    op_valid_nxt_s = 1'b1;
                    state_nxt_s    = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_PLAY;
                end
            end
            ST_ISSUE: begin
                // A DROP that cannot move means the piece has landed.
                if (op_done) begin
                    op_valid_nxt_s = 1'b0;
                    if ((op_code_r == OP_DROP) && !op_ok) begin
                        state_nxt_s = ST_LOCK;
                    end else begin
                        state_nxt_s = ST_PLAY;
                    end
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_LOCK: begin
                if (!op_valid_r) begin
                    op_valid_nxt_s = 1'b1;
                    op_code_nxt_s  = OP_LOCK;
                end else if (op_done) begin
                    op_valid_nxt_s = 1'b0;
                    state_nxt_s    = ST_CLEAR;
                end else begin
                    state_nxt_s = ST_LOCK;
                end
            end
            ST_CLEAR: begin
                if (!op_valid_r) begin
                    op_valid_nxt_s = 1'b1;
                    op_code_nxt_s  = OP_CLEAR;
                end else if (op_done) begin
                    op_valid_nxt_s = 1'b0;
                    if (op_ok) begin
                        state_nxt_s = ST_CLEAR;
                    end else begin
                        state_nxt_s = ST_SPAWN;
                    end
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            ST_SPAWN: begin
                if (!op_valid_r) begin
                    op_valid_nxt_s = 1'b1;
                    op_code_nxt_s  = OP_SPAWN;
                end else if (op_done) begin
                    op_valid_nxt_s = 1'b0;
                    if (op_ok) begin
                        state_nxt_s = ST_PLAY;
                        flush_s     = 1'b1;
                    end else begin
                        state_nxt_s = ST_OVER;
                    end
                end else begin
                    state_nxt_s = ST_SPAWN;
                end
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                op_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // Pending flags: new edges win over a same-cycle grant; a successful spawn wipes all.
    always_comb begin
        pend_nxt_s = pend_r;
        grav_nxt_s = grav_pend_r;
        if (flush_s) begin
            pend_nxt_s = 4'd0;
            grav_nxt_s = 1'b0;
        end else if (arm_s) begin
            pend_nxt_s = (pend_r & ~grant_s) | btn_edge_s[3:0];
            grav_nxt_s = (grav_pend_r & ~grant_grav_s) | tick_s;
        end else begin
            pend_nxt_s = pend_r & ~grant_s;
            grav_nxt_s = (grav_pend_r & ~grant_grav_s) | tick_s;
        end
    end

    // State, flag and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            op_valid_r  <= 1'b0;
            op_code_r   <= OP_NEW;
            level_r     <= 3'd0;
            playing_r   <= 1'b0;
            game_over_r <= 1'b0;
            btn_prev_r  <= 5'd0;
            pend_r      <= 4'd0;
            grav_pend_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            op_valid_r  <= op_valid_nxt_s;
            op_code_r   <= op_code_nxt_s;
            level_r     <= level_of(32'(score), LEVEL_STEP);
            playing_r   <= (state_nxt_s == ST_PLAY) || (state_nxt_s == ST_ISSUE) ||
                           (state_nxt_s == ST_LOCK) || (state_nxt_s == ST_CLEAR) ||
                           (state_nxt_s == ST_SPAWN);
            game_over_r <= (state_nxt_s == ST_OVER);
            btn_prev_r  <= btn_s;
            pend_r      <= pend_nxt_s;
            grav_pend_r <= grav_nxt_s;
        end
    end

endmodule

// File: tb/tb_tetris_sched.sv
// Directed-plus-random bench for tetris_sched with a small engine responder
// and a rule-level model of priority, level and gravity period.
module tb_tetris_sched;

    localparam logic [2:0] C_NEW   = 3'd0;
    localparam logic [2:0] C_LEFT  = 3'd1;
    localparam logic [2:0] C_RIGHT = 3'd2;
    localparam logic [2:0] C_ROT   = 3'd3;
    localparam logic [2:0] C_DROP  = 3'd4;
    localparam logic [2:0] C_LOCK  = 3'd5;
    localparam logic [2:0] C_CLEAR = 3'd6;
    localparam logic [2:0] C_SPAWN = 3'd7;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        btn_left = 1'b0, btn_right = 1'b0, btn_down = 1'b0, btn_rot = 1'b0, btn_start = 1'b0;
    logic [12:0] score = 13'd0;
    logic        op_done = 1'b0, op_ok = 1'b0;
    logic        op_valid, playing, game_over;
    logic [2:0]  op_code, level;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tetris_sched #(.TICK_BASE(64), .TICK_MIN(8), .LEVEL_STEP(100), .SCORE_W(13)) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_left(btn_left), .btn_right(btn_right), .btn_down(btn_down),
        .btn_rot(btn_rot), .btn_start(btn_start),
        .score(score), .op_valid(op_valid), .op_code(op_code),
        .op_done(op_done), .op_ok(op_ok),
        .level(level), .playing(playing), .game_over(game_over)
    );

    function automatic int model_level(input int s);
        int l;
        l = s / 100;
        return (l > 7) ? 7 : l;
    endfunction

    function automatic int model_period(input int l);
        int p;
        p = 64 >> l;
        return (p < 8) ? 8 : p;
    endfunction

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic [4:0] m, input int h);
        btn_left = m[0]; btn_right = m[1]; btn_down = m[2]; btn_rot = m[3]; btn_start = m[4];
        repeat (h) @(negedge clk);
        btn_left = 1'b0; btn_right = 1'b0; btn_down = 1'b0; btn_rot = 1'b0; btn_start = 1'b0;
    endtask

    // Engine side: wait for a request, check its code and stability, then ack.
    task automatic do_op(input logic [2:0] code, input logic ok, input int hold,
                         input string tag, output int t_seen);
        int w;
        w = 0;
        while (op_valid !== 1'b1 && w < 400) begin
            @(negedge clk);
            w++;
        end
        t_seen = cyc;
        chk(32'(op_valid), 32'd1, {tag, "/valid"});
        if (op_valid === 1'b1) begin
            chk(32'(op_code), 32'(code), {tag, "/code"});
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk(32'({op_valid, op_code}), 32'({1'b1, code}), {tag, "/stable"});
            end
            op_done = 1'b1;
            op_ok   = ok;
            @(negedge clk);
            op_done = 1'b0;
            op_ok   = 1'b0;
            chk(32'(op_valid), 32'd0, {tag, "/release"});
        end
    endtask

    initial begin
        int t0, t1, t2, t3, t4, t5, t6, t7, tb, ta, tn, t_prev, td, cur_p, s, lvl, p, n, w;
        logic [3:0] mask;
        logic [2:0] q[$];

        // Reset values
        repeat (2) @(negedge clk);
        chk(32'(op_valid), 32'd0, "rst_valid");
        chk(32'(op_code), 32'd0, "rst_code");
        chk(32'(level), 32'd0, "rst_level");
        chk(32'(playing), 32'd0, "rst_playing");
        chk(32'(game_over), 32'd0, "rst_over");
        rst_n = 1'b1;
        @(negedge clk);

        // Stray op_done in IDLE does nothing
        op_done = 1'b1;
        @(negedge clk);
        op_done = 1'b0;
        @(negedge clk);
        chk(32'(op_valid), 32'd0, "idle_stray_done");
        chk(32'(playing), 32'd0, "idle_playing");

        // Start: NEW then SPAWN
        pulse(5'b10000, 1);
        do_op(C_NEW, 1'b1, 1, "new", td);
        do_op(C_SPAWN, 1'b1, 0, "spawn", td);
        chk(32'(playing), 32'd1, "start_playing");
        chk(32'(level), 32'd0, "start_level");
        chk(32'(game_over), 32'd0, "start_over");

        // Same-cycle left+rot, left held 10 cycles: ROT, LEFT, then only gravity
        btn_rot = 1'b1; btn_left = 1'b1;
        @(negedge clk);
        btn_rot = 1'b0;
        repeat (9) @(negedge clk);
        btn_left = 1'b0;
        do_op(C_ROT, 1'b1, 0, "prio_rot", td);
        do_op(C_LEFT, 1'b0, 0, "prio_left", td);
        do_op(C_DROP, 1'b1, 0, "grav_first", t0);

        // Gravity scaling
        do_op(C_DROP, 1'b1, 0, "grav_l0", t1);
        chk(32'(t1 - t0), 32'd64, "period_l0");
        score = 13'd250;
        do_op(C_DROP, 1'b1, 0, "grav_chg2", t2);
        chk(32'(t2 - t1), 32'd64, "no_truncate_l2");
        chk(32'(level), 32'd2, "level_250");
        do_op(C_DROP, 1'b1, 0, "grav_l2", t3);
        chk(32'(t3 - t2), 32'd16, "period_l2");
        score = 13'd900;
        do_op(C_DROP, 1'b1, 0, "grav_chg7", t4);
        chk(32'(t4 - t3), 32'd16, "no_truncate_l7");
        do_op(C_DROP, 1'b1, 0, "grav_l7", t5);
        chk(32'(t5 - t4), 32'd8, "period_l7");
        chk(32'(level), 32'd7, "level_900");

        // Tick during a long DROP in ISSUE is serviced right after
        do_op(C_DROP, 1'b1, 12, "grav_hold", t5);
        tb = cyc;
        do_op(C_DROP, 1'b1, 0, "grav_merged", t6);
        chk(32'(t6 - tb), 32'd1, "collision");
        do_op(C_DROP, 1'b1, 0, "grav_resync", t7);

        // Random scores
        t_prev = t7;
        cur_p  = 8;
        for (int i = 0; i < 3; i++) begin
            s     = int'($urandom_range(0, 999));
            score = 13'(s);
            lvl   = model_level(s);
            p     = model_period(lvl);
            do_op(C_DROP, 1'b1, 0, "rs_old", ta);
            chk(32'(ta - t_prev), 32'(cur_p), "rs_period_old");
            do_op(C_DROP, 1'b1, 0, "rs_new", tn);
            chk(32'(tn - ta), 32'(p), "rs_period_new");
            chk(32'(level), 32'(lvl), "rs_level");
            t_prev = tn;
            cur_p  = p;
        end

        // Back to level 0 for a wide gravity window
        score = 13'd0;
        do_op(C_DROP, 1'b1, 0, "settle_a", td);
        do_op(C_DROP, 1'b1, 0, "settle_b", td);

        // Random button sets after each gravity drop, served in priority order
        for (int it = 0; it < 6; it++) begin
            mask = 4'($urandom_range(1, 15));
            pulse({1'b0, mask}, int'($urandom_range(1, 4)));
            q.delete();
            if (mask[2]) q.push_back(C_DROP);
            if (mask[3]) q.push_back(C_ROT);
            if (mask[0]) q.push_back(C_LEFT);
            if (mask[1]) q.push_back(C_RIGHT);
            foreach (q[k]) begin
                do_op(q[k], (q[k] == C_DROP) ? 1'b1 : 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 2)), "rand_prio", td);
            end
            do_op(C_DROP, 1'b1, 0, "rand_sync", td);
        end

        // Landing chain
        do_op(C_DROP, 1'b0, 0, "land_drop", td);
        do_op(C_LOCK, 1'b1, 0, "land_lock", td);
        chk(32'(playing), 32'd1, "land_playing");
        do_op(C_CLEAR, 1'b1, 0, "land_clr1", td);
        do_op(C_CLEAR, 1'b1, 1, "land_clr2", td);
        do_op(C_CLEAR, 1'b0, 0, "land_clr3", td);
        do_op(C_SPAWN, 1'b1, 0, "land_spawn", td);
        chk(32'(playing), 32'd1, "land_play_again");

        // Game over
        do_op(C_DROP, 1'b0, 0, "go_drop", td);
        do_op(C_LOCK, 1'b1, 0, "go_lock", td);
        do_op(C_CLEAR, 1'b0, 0, "go_clear", td);
        do_op(C_SPAWN, 1'b0, 0, "go_spawn", td);
        chk(32'(game_over), 32'd1, "go_flag");
        chk(32'(playing), 32'd0, "go_playing");
        pulse(5'b01111, 2);
        n = 0;
        repeat (80) begin
            @(negedge clk);
            if (op_valid === 1'b1) n++;
        end
        chk(32'(n), 32'd0, "go_quiet");
        pulse(5'b10000, 1);
        do_op(C_NEW, 1'b1, 0, "go_new", td);
        do_op(C_SPAWN, 1'b1, 0, "go_respawn", td);
        chk(32'(game_over), 32'd0, "go_cleared");
        chk(32'(playing), 32'd1, "go_replaying");

        // Start while playing is ignored; gravity is next
        pulse(5'b10000, 1);
        do_op(C_DROP, 1'b1, 0, "start_in_play", td);

        // Reset in the middle of an op
        score = 13'd500;
        pulse(5'b00001, 1);
        w = 0;
        while (op_valid !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk(32'({op_valid, op_code}), 32'({1'b1, C_LEFT}), "midop_issue");
        chk(32'(level), 32'd5, "midop_level");
        #2 rst_n = 1'b0;
        #1;
        chk(32'(op_valid), 32'd0, "arst_valid");
        chk(32'(op_code), 32'd0, "arst_code");
        chk(32'(level), 32'd0, "arst_level");
        chk(32'(playing), 32'd0, "arst_playing");
        chk(32'(game_over), 32'd0, "arst_over");
        @(negedge clk);
        op_done = 1'b1;
        op_ok   = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        op_done = 1'b0;
        op_ok   = 1'b0;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (op_valid === 1'b1) n++;
        end
        chk(32'(n), 32'd0, "late_done_ignored");
        chk(32'(playing), 32'd0, "post_rst_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tetris_sched.md
# tetris_sched

Move scheduler for the Tetris game core. It shares the single piece-move/collision datapath inside the game engine between four button requesters and a score-scaled gravity timer. It also sequences the lock → row-clear → spawn chain after a piece lands, and the new-game/game-over flow. It sits between the debounced button inputs and the engine's op port; the score feeds back from the engine for level selection.

## Interface
- `TICK_BASE`, default 50_000_000: clock cycles per gravity step at level 0.
- `TICK_MIN`, default 3_125_000: floor on the gravity interval.
- `LEVEL_STEP`, default 100: score points per level.
- `SCORE_W`, default 13: score width.
- `clk`  in  1: system clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `btn_left`, `btn_right`, `btn_down`, `btn_rot`, `btn_start`  in  1 each: debounced levels, synchronous to `clk`.
- `score`  in  `SCORE_W`: current score from the engine.
- `op_valid`  out  1: op request to the engine.
- `op_code`  out  3: 0 NEW, 1 LEFT, 2 RIGHT, 3 ROT, 4 DROP, 5 LOCK, 6 CLEAR, 7 SPAWN.
- `op_done`  in  1: one-cycle completion strobe from the engine.
- `op_ok`  in  1: result, valid with `op_done`. Meaning: move legal, row cleared, or spawn fit.
- `level`  out  3: current level, 0..7.
- `playing`  out  1: high in PLAY/ISSUE/LOCK/CLEAR/SPAWN.
- `game_over`  out  1: high in OVER.

## Operation
- **Edge detect.** A rising edge on `btn_*` sets the matching pending flag. A held button yields one op (no autorepeat). An edge while the flag is already set merges into that flag.
- **Level.** Level = number of thresholds k·`LEVEL_STEP` (k = 1..7) that `score` is ≥ to, saturating at 7. Computed with a constant compare chain; no divider.
- **Gravity interval.** Interval = max(`TICK_BASE` >> level, `TICK_MIN`). The gravity timer sets `grav_pend` when its count reaches interval−1, then restarts at 0.
- **States:**
  - IDLE: wait for a start edge → issue NEW → SPAWN.
  - PLAY: pick the highest pending request. Priority: gravity > down > rot > left > right. Gravity and down both issue DROP. The granted flag clears on issue → ISSUE.
  - ISSUE: hold `op_valid` until `op_done`. If a DROP returns `op_ok`=0 → LOCK. Otherwise → PLAY; failed LEFT/RIGHT/ROT are dropped silently.
  - LOCK: issue LOCK → CLEAR.
  - CLEAR: issue CLEAR repeatedly while `op_ok`=1; the first `op_ok`=0 → SPAWN.
  - SPAWN: issue SPAWN. `op_ok`=1 → PLAY with the timer zeroed and all pending flags cleared. `op_ok`=0 → OVER.
  - OVER: `game_over`=1; button flags are ignored. A start edge → issue NEW → SPAWN.
- **Start in play.** `btn_start` edges in PLAY are ignored.
- **Timer gating.** The gravity timer counts only in PLAY and ISSUE; it is held in all other states.
- **Gravity collision.** A gravity tick that fires while a DROP is in ISSUE still sets `grav_pend`; it is serviced next in PLAY.

## Timing
- **Reset values:** `op_valid`=0, `op_code`=0, `level`=0, `playing`=0, `game_over`=0, state IDLE, timer 0, all flags 0. Reset mid-op abandons the op immediately.
- **Request latency:** button sampled high at edge k → pending flag set at k → `op_valid` at k+1 (if in PLAY with no higher-priority flag).
- **Handshake:**
  - `op_code` is stable while `op_valid`=1.
  - `op_done` sampled at edge n → `op_valid`=0 from n.
  - The next `op_valid` is no earlier than n+1.
  - `op_done` while `op_valid`=0 is ignored.
- **Flag updates:** a new edge arriving in the same cycle as `op_done` is kept. A same-cycle grant and new edge of the same button leave the flag set.
- **Level timing:** `level` is registered, one cycle behind `score`. A level change takes effect on the next timer restart, never truncating the current count.

## Structure
- `tetris_pkg` holds the op code constants, the state encoding, and the level/threshold count (7).
- Sub-module `tetris_grav_timer` contains the counter, the interval shift with floor, and the `tick` pulse. Its inputs are `clk`, `rst_n`, `run`, `clr`, and `level`.
- The arbiter, pending flags and FSM live in `tetris_sched`.

## Test plan
- **Start and first move:** reset, pulse `btn_start` → NEW then SPAWN issued; ack SPAWN with `op_ok`=1 → `playing`=1, `level`=0.
- **Priority:** `TICK_BASE`=64. Set `btn_left` and `btn_rot` in the same cycle → ROT issued first, then LEFT. A 10-cycle `btn_left` hold → exactly one LEFT.
- **Gravity scaling:** `TICK_BASE`=64, `TICK_MIN`=8. `score`=0 → DROP every 64 cycles in PLAY. `score`=250 → level 2, period 16. `score`=900 → level 7, period 8.
- **Landing chain:** DROP acked with `op_ok`=0 → LOCK, then CLEAR acked with `op_ok`=1, 1, 0 (three CLEARs total), then SPAWN.
- **Game over:** SPAWN acked with `op_ok`=0 → `game_over`=1; buttons issue nothing; `btn_start` → NEW.
- **Reset mid-op:** assert `rst_n`=0 while `op_valid`=1 in ISSUE → all outputs return to reset values asynchronously; a late `op_done` is ignored.
